// File: rtl/data_island_multi_packet_serializer_if.sv
// Packet bus between an infoframe/audio packet scheduler and the data island
// serializer. A packet moves on a rising edge where packetValid && packetReady.
interface data_island_multi_packet_serializer_if;
    logic         packetValid;
    logic         packetReady;
    logic [23:0]  header;      // HB0..HB2, bit 0 sent first
    logic [223:0] subpackets;  // SB0 = [55:0] ... SB3 = [223:168]

    modport master (
        output packetValid,
        output header,
        output subpackets,
        input  packetReady
    );

    modport slave (
        input  packetValid,
        input  header,
        input  subpackets,
        output packetReady
    );
endinterface

// File: rtl/data_island_multi_packet_serializer.sv
// HDMI data island serializer: lead guard band, N packets of 32 clocks each,
// trail guard band. Produces the TERC4 nibble streams with the header and
// subpacket BCH ECC computed on acceptance. A null packet is substituted
// (and underrun flagged) when no packet is offered at a slot boundary.
module data_island_multi_packet_serializer #(
    parameter int unsigned MAX_PACKETS  = 18,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic                               clock,
    input  logic                               resetN,
    input  logic                               islandStart,
    input  logic [$clog2(MAX_PACKETS+1)-1:0]   packetCount,
    input  logic                               hsync,
    input  logic                               vsync,
    data_island_multi_packet_serializer_if.slave pkt,
    output logic [3:0]                         terc4channel0,
    output logic [3:0]                         terc4channel1,
    output logic [3:0]                         terc4channel2,
    output logic                               isGuard,
    output logic                               isDataIsland,
    output logic                               busy,
    output logic                               underrun
);

    localparam int unsigned CNT_W = $clog2(MAX_PACKETS + 1);
    localparam int unsigned GRD_W = $clog2(GUARD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_PACKETS);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [GRD_W-1:0] GUARD_LAST = GRD_W'(GUARD_CYCLES - 1);
    localparam logic [GRD_W-1:0] GUARD_ONE  = GRD_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        LEAD_GUARD,
        PACKET,
        TRAIL_GUARD
    } state_t;

    state_t                 state_q, state_d;
    logic [GRD_W-1:0]       guard_q, guard_d;
    logic [4:0]             clk_cnt_q, clk_cnt_d;
    logic [CNT_W-1:0]       slot_q, slot_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [23:0]            hdr_q, hdr_d;
    logic [7:0]             hecc_q, hecc_d;
    logic [3:0][55:0]       sb_q, sb_d;
    logic [3:0][7:0]        secc_q, secc_d;
    logic                   underrun_q, underrun_d;

    logic [3:0]             ch0_q, ch0_d;
    logic [3:0]             ch1_q, ch1_d;
    logic [3:0]             ch2_q, ch2_d;
    logic                   is_guard_q, is_guard_d;
    logic                   is_island_q, is_island_d;
    logic                   busy_q, busy_d;
    logic                   packet_ready_q, packet_ready_d;

    logic                   accept;
    logic [31:0]            hdr_lane;
    logic [63:0]            sb_lane;

    // BCH ECC over the first nbits of data, LSB first, polynomial 0x83.
    function automatic logic [7:0] bch_ecc(input logic [55:0] data, input int unsigned nbits);
        logic [7:0] ecc;
        logic       f;
        ecc = '0;
        for (int unsigned i = 0; i < 56; i++) begin
            if (i < nbits) begin
                f   = ecc[0] ^ data[i];
                ecc = (ecc >> 1) ^ (f ? 8'h83 : 8'h00);
            end
        end
        return ecc;
    endfunction

    // packetReady is a registered pulse, so the handshake completes on the
    // edge right after it is seen high.
    assign accept = packet_ready_q;

    // Island sequencing and packet capture for the next cycle.
    always_comb begin
        state_d    = state_q;
        guard_d    = guard_q;
        clk_cnt_d  = clk_cnt_q;
        slot_d     = slot_q;
        count_d    = count_q;
        underrun_d = underrun_q;
        hdr_d      = hdr_q;
        hecc_d     = hecc_q;
        sb_d       = sb_q;
        secc_d     = secc_q;

        case (state_q)
            IDLE: begin
                if (islandStart && (packetCount != '0) && (packetCount <= CNT_MAX)) begin
                    state_d    = LEAD_GUARD;
                    guard_d    = '0;
                    count_d    = packetCount;
                    underrun_d = 1'b0;
                end
            end
            LEAD_GUARD: begin
                if (guard_q == GUARD_LAST) begin
                    state_d   = PACKET;
                    clk_cnt_d = '0;
                    slot_d    = '0;
                end else begin
                    guard_d = guard_q + GUARD_ONE;
                end
            end
            PACKET: begin
                if (clk_cnt_q == 5'd31) begin
                    clk_cnt_d = '0;
                    if (slot_q == count_q - CNT_ONE) begin
                        state_d = TRAIL_GUARD;
                        guard_d = '0;
                    end else begin
                        slot_d = slot_q + CNT_ONE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 5'd1;
                end
            end
            TRAIL_GUARD: begin
                if (guard_q == GUARD_LAST) begin
                    state_d = IDLE;
                end else begin
                    guard_d = guard_q + GUARD_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            hdr_d = pkt.packetValid ? pkt.header : '0;
            for (int unsigned k = 0; k < 4; k++) begin
                sb_d[k] = pkt.packetValid ? pkt.subpackets[k*56 +: 56] : '0;
            end
            hecc_d = bch_ecc({32'h0, hdr_d}, 24);
            for (int unsigned k = 0; k < 4; k++) begin
                secc_d[k] = bch_ecc(sb_d[k], 56);
            end
            if (!pkt.packetValid) begin
                underrun_d = 1'b1;
            end
        end
    end

    // Output values for the cycle the next state describes, so every output
    // is a flop yet lines up with the state it reports.
    always_comb begin
        ch0_d          = {2'b00, vsync, hsync};
        ch1_d          = '0;
        ch2_d          = '0;
        is_guard_d     = 1'b0;
        is_island_d    = 1'b0;
        packet_ready_d = 1'b0;
        busy_d         = (state_d != IDLE);
        hdr_lane       = {hecc_d, hdr_d};
        sb_lane        = '0;

        case (state_d)
            LEAD_GUARD: begin
                ch0_d[3:2]     = 2'b11;
                is_guard_d     = 1'b1;
                packet_ready_d = (guard_d == GUARD_LAST);
            end
            TRAIL_GUARD: begin
                ch0_d[3:2] = 2'b11;
                is_guard_d = 1'b1;
            end
            PACKET: begin
                is_island_d    = 1'b1;
                ch0_d[2]       = hdr_lane[clk_cnt_d];
                ch0_d[3]       = !((slot_d == '0) && (clk_cnt_d == '0));
                for (int unsigned k = 0; k < 4; k++) begin
                    sb_lane  = {secc_d[k], sb_d[k]};
                    ch1_d[k] = sb_lane[{clk_cnt_d, 1'b0}];
                    ch2_d[k] = sb_lane[{clk_cnt_d, 1'b1}];
                end
                packet_ready_d = (clk_cnt_d == 5'd31) && (slot_d != count_q - CNT_ONE);
            end
            default: ;
        endcase
    end

    // State, held packet and registered outputs.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q        <= IDLE;
            guard_q        <= '0;
            clk_cnt_q      <= '0;
            slot_q         <= '0;
            count_q        <= '0;
            hdr_q          <= '0;
            hecc_q         <= '0;
            sb_q           <= '0;
            secc_q         <= '0;
            underrun_q     <= 1'b0;
            ch0_q          <= '0;
            ch1_q          <= '0;
            ch2_q          <= '0;
            is_guard_q     <= 1'b0;
            is_island_q    <= 1'b0;
            busy_q         <= 1'b0;
            packet_ready_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            guard_q        <= guard_d;
            clk_cnt_q      <= clk_cnt_d;
            slot_q         <= slot_d;
            count_q        <= count_d;
            hdr_q          <= hdr_d;
            hecc_q         <= hecc_d;
            sb_q           <= sb_d;
            secc_q         <= secc_d;
            underrun_q     <= underrun_d;
            ch0_q          <= ch0_d;
            ch1_q          <= ch1_d;
            ch2_q          <= ch2_d;
            is_guard_q     <= is_guard_d;
            is_island_q    <= is_island_d;
            busy_q         <= busy_d;
            packet_ready_q <= packet_ready_d;
        end
    end

    assign terc4channel0   = ch0_q;
    assign terc4channel1   = ch1_q;
    assign terc4channel2   = ch2_q;
    assign isGuard         = is_guard_q;
    assign isDataIsland    = is_island_q;
    assign busy            = busy_q;
    assign underrun        = underrun_q;
    assign pkt.packetReady = packet_ready_q;

endmodule

// File: tb/tb_data_island_multi_packet_serializer.sv
// Self-checking bench for data_island_multi_packet_serializer.
module tb_data_island_multi_packet_serializer;

    localparam int MAXP = 18;
    localparam int GC   = 2;

    logic       clock = 1'b0;
    logic       resetN = 1'b0;
    logic       islandStart = 1'b0;
    logic [4:0] packetCount = '0;
    logic       hsync = 1'b0;
    logic       vsync = 1'b0;
    logic [3:0] ch0, ch1, ch2;
    logic       isGuard, isDataIsland, busy, underrun;

    data_island_multi_packet_serializer_if bus ();

    data_island_multi_packet_serializer #(
        .MAX_PACKETS (MAXP),
        .GUARD_CYCLES(GC)
    ) dut (
        .clock        (clock),
        .resetN       (resetN),
        .islandStart  (islandStart),
        .packetCount  (packetCount),
        .hsync        (hsync),
        .vsync        (vsync),
        .pkt          (bus),
        .terc4channel0(ch0),
        .terc4channel1(ch1),
        .terc4channel2(ch2),
        .isGuard      (isGuard),
        .isDataIsland (isDataIsland),
        .busy         (busy),
        .underrun     (underrun)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [23:0]  hdr;
        logic [223:0] sb;
        logic         valid;
    } pkt_t;

    pkt_t       pk [MAXP];
    logic [7:0] cap_hecc;

    task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%h want=%h", name, t, act, exp);
        end
    endtask

    // Reference BCH ECC straight from the definition.
    function automatic logic [7:0] ref_ecc(input logic [55:0] d, input int n);
        logic [7:0] e;
        logic       f;
        e = '0;
        for (int i = 0; i < n; i++) begin
            f = e[0] ^ d[i];
            e = (e >> 1) ^ (f ? 8'h83 : 8'h00);
        end
        return e;
    endfunction

    function automatic logic [223:0] rand_sb();
        logic [223:0] r;
        for (int i = 0; i < 7; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic drive_bus(input int s, input int n);
        if (s < n) begin
            bus.header      = pk[s].hdr;
            bus.subpackets  = pk[s].sb;
            bus.packetValid = pk[s].valid;
        end else begin
            bus.header      = 24'($urandom);
            bus.subpackets  = rand_sb();
            bus.packetValid = 1'($urandom);
        end
    endtask

    // Runs one island of n packets from pk[], checking every output cycle
    // from the first guard cycle through the first IDLE cycle afterwards.
    task automatic run_island(input int n, input bit toggle_sync, input bit poke_start);
        int          L, p, c, slot_nxt, pulses;
        bit          acc_pend;
        logic        ur, hs_s, vs_s, eg, edi, erdy;
        logic [3:0]  e0, e1, e2;
        logic [23:0] h;
        logic [55:0] s;
        logic [31:0] lane0;
        logic [63:0] lane;
        L = 2*GC + 32*n;
        slot_nxt = 0;
        pulses = 0;
        acc_pend = 1'b0;
        ur = 1'b0;
        islandStart = 1'b1;
        packetCount = 5'(n);
        drive_bus(0, n);
        for (int t = 0; t <= L; t++) begin
            if (toggle_sync) begin
                hsync = ~hsync;
                vsync = 1'($urandom);
            end
            @(posedge clock);
            hs_s = hsync;
            vs_s = vsync;
            #1;
            e0 = {2'b00, vs_s, hs_s};
            e1 = '0;
            e2 = '0;
            eg = 1'b0;
            edi = 1'b0;
            erdy = 1'b0;
            if (t < L) begin
                if (t < GC || t >= GC + 32*n) begin
                    eg = 1'b1;
                    e0[3:2] = 2'b11;
                    erdy = (t == GC - 1);
                end else begin
                    p = (t - GC) / 32;
                    c = (t - GC) % 32;
                    edi = 1'b1;
                    h = pk[p].valid ? pk[p].hdr : 24'h0;
                    lane0 = {ref_ecc({32'h0, h}, 24), h};
                    e0[3] = !(p == 0 && c == 0);
                    e0[2] = lane0[c];
                    for (int k = 0; k < 4; k++) begin
                        s = pk[p].valid ? pk[p].sb[k*56 +: 56] : 56'h0;
                        lane = {ref_ecc(s, 56), s};
                        e1[k] = lane[2*c];
                        e2[k] = lane[2*c+1];
                    end
                    if (c == 0 && !pk[p].valid) ur = 1'b1;
                    erdy = (c == 31) && (p < n - 1);
                    if (p == 0 && c >= 24) cap_hecc[c-24] = ch0[2];
                end
            end
            chk("ch0", t, 32'(ch0), 32'(e0));
            chk("ch1", t, 32'(ch1), 32'(e1));
            chk("ch2", t, 32'(ch2), 32'(e2));
            chk("isGuard", t, 32'(isGuard), 32'(eg));
            chk("isDataIsland", t, 32'(isDataIsland), 32'(edi));
            chk("busy", t, 32'(busy), 32'(t < L));
            chk("packetReady", t, 32'(bus.packetReady), 32'(erdy));
            chk("underrun", t, 32'(underrun), 32'(ur));
            if (bus.packetReady) pulses++;
            if (acc_pend) begin
                slot_nxt++;
                drive_bus(slot_nxt, n);
            end
            acc_pend = erdy;
            islandStart = poke_start && (t < L);
            packetCount = poke_start ? 5'($urandom) : 5'(n);
        end
        islandStart = 1'b0;
        chk("ready_pulses", L, 32'(pulses), 32'(n));
    endtask

    typedef struct {
        logic [23:0] hdr;
        logic [7:0]  ecc;
    } ecc_vec_t;

    typedef struct {
        logic       start;
        logic [4:0] count;
        logic       hs;
        logic       vs;
        logic       exp_busy;
        logic [3:0] exp_ch0;
        logic       exp_underrun;
    } idle_vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ecc_vec_t  ev [5];
        idle_vec_t iv [5];
        int        n;

        ev[0] = '{24'h000000, 8'h00};
        ev[1] = '{24'h000001, 8'h4A};
        ev[2] = '{24'h800000, 8'h83};
        ev[3] = '{24'h400000, 8'hC2};
        ev[4] = '{24'hC00001, 8'h0B};

        iv[0] = '{1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 4'b0000, 1'b1};
        iv[1] = '{1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 4'b0001, 1'b1};
        iv[2] = '{1'b1, 5'd19, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b1};
        iv[3] = '{1'b1, 5'd31, 1'b1, 1'b1, 1'b0, 4'b0011, 1'b1};
        iv[4] = '{1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 4'b0001, 1'b1};

        bus.packetValid = 1'b0;
        bus.header      = '0;
        bus.subpackets  = '0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("reset_outputs", 0,
            {20'h0, ch0, ch1, ch2, isGuard, isDataIsland, busy, underrun, 4'h0},
            32'h0);
        chk("reset_ready", 0, 32'(bus.packetReady), 32'h0);
        resetN = 1'b1;
        @(posedge clock);
        #1;
        chk("idle_after_reset", 0, {27'h0, busy, ch0}, 32'h0);

        // Header ECC vectors on single-packet islands with zero subpackets
        for (int i = 0; i < 5; i++) begin
            pk[0].hdr   = ev[i].hdr;
            pk[0].sb    = '0;
            pk[0].valid = 1'b1;
            run_island(1, 1'b0, 1'b0);
            chk("hdr_ecc", i, 32'(cap_hecc), 32'(ev[i].ecc));
        end

        // Three random packets, sync toggling, starts poked while busy
        for (int i = 0; i < 3; i++) begin
            pk[i].hdr = 24'($urandom);
            pk[i].sb = rand_sb();
            pk[i].valid = 1'b1;
        end
        run_island(3, 1'b1, 1'b1);

        // Random islands with occasional missing packets, then a full-size one
        for (int r = 0; r < 5; r++) begin
            n = (r == 4) ? MAXP : $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                pk[i].hdr = 24'($urandom);
                pk[i].sb = rand_sb();
                pk[i].valid = ($urandom_range(0, 3) != 0);
            end
            run_island(n, 1'b1, (r % 2) == 1);
        end

        // Underrun on the second slot; stays set through ignored starts
        pk[0].hdr = 24'($urandom);
        pk[0].sb = rand_sb();
        pk[0].valid = 1'b1;
        pk[1].hdr = 24'($urandom);
        pk[1].sb = rand_sb();
        pk[1].valid = 1'b0;
        run_island(2, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            hsync = iv[i].hs;
            vsync = iv[i].vs;
            islandStart = iv[i].start;
            packetCount = iv[i].count;
            @(posedge clock);
            #1;
            chk("idle_busy", i, 32'(busy), 32'(iv[i].exp_busy));
            chk("idle_ch0", i, 32'(ch0), 32'(iv[i].exp_ch0));
            chk("idle_underrun", i, 32'(underrun), 32'(iv[i].exp_underrun));
            chk("idle_guard", i, 32'(isGuard), 32'h0);
        end
        islandStart = 1'b0;
        pk[0].valid = 1'b1;
        run_island(1, 1'b0, 1'b0);

        // Reset asserted at packet clock 13 of slot 1 (null packet there)
        pk[0].hdr = 24'($urandom);
        pk[0].sb = rand_sb();
        pk[0].valid = 1'b1;
        pk[1].valid = 1'b0;
        islandStart = 1'b1;
        packetCount = 5'd2;
        drive_bus(0, 2);
        for (int t = 0; t <= GC + 32 + 13; t++) begin
            @(posedge clock);
            #1;
            islandStart = 1'b1;
            packetCount = 5'd0;
            if (t == GC) drive_bus(1, 2);
        end
        chk("pre_reset_underrun", 0, 32'(underrun), 32'h1);
        chk("pre_reset_busy", 0, 32'(busy), 32'h1);
        #2;
        resetN = 1'b0;
        #1;
        chk("mid_reset_outputs", 0,
            {20'h0, ch0, ch1, ch2, isGuard, isDataIsland, busy, underrun, 4'h0},
            32'h0);
        chk("mid_reset_ready", 0, 32'(bus.packetReady), 32'h0);
        islandStart = 1'b1;
        packetCount = 5'd2;
        repeat (2) @(posedge clock);
        #1;
        islandStart = 1'b0;
        resetN = 1'b1;
        hsync = 1'b1;
        vsync = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(posedge clock);
            #1;
            chk("post_reset_busy", t, 32'(busy), 32'h0);
            chk("post_reset_ch0", t, 32'(ch0), 32'h1);
            chk("post_reset_flags", t, {29'h0, isGuard, isDataIsland, underrun}, 32'h0);
        end
        pk[0].valid = 1'b1;
        run_island(1, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
